// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a LEN / {HI,LO}*N / XOR-checksum byte frame
// and issues one wr_en pulse per 16-bit word, holding the core in busy meanwhile.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE
  } state_t;

  state_t                state_q, state_n;
  logic [BYTE_W-1:0]     len_q, len_n;
  logic [BYTE_W-1:0]     cnt_q, cnt_n;
  logic [BYTE_W-1:0]     hi_q, hi_n;
  logic [BYTE_W-1:0]     csum_q, csum_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n;
  logic [WORD_W-1:0]     wr_data_n;
  logic                  wr_en_n, in_ready_n, busy_n, done_n, error_n;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // Next-state and next-register values; outputs are registered from state_n.
  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    cnt_n     = cnt_q;
    hi_n      = hi_q;
    csum_n    = csum_q;
    addr_n    = addr_q;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    busy_n    = busy;
    done_n    = done;
    error_n   = error;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_LEN;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          error_n = 1'b0;
          csum_n  = '0;
          addr_n  = ADDR_WIDTH'(BASE_ADDR);
          cnt_n   = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_n   = in_data;
          state_n = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_n    = in_data;
          csum_n  = csum_q ^ in_data;
          state_n = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          wr_data_n = {hi_q, in_data};
          wr_addr_n = addr_q;
          csum_n    = csum_q ^ in_data;
          state_n   = S_WR;
        end
      end
      S_WR: begin
        // LEN of 0 wraps to 255 here, giving a 256-word frame.
        if (cnt_q == len_q - BYTE_W'(1)) begin
          state_n = S_CHK;
        end else begin
          addr_n  = addr_q + ADDR_WIDTH'(1);
          cnt_n   = cnt_q + BYTE_W'(1);
          state_n = S_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          error_n = (in_data != csum_q);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    wr_en_n    = (state_n == S_WR);
    in_ready_n = (state_n == S_LEN) || (state_n == S_HI) ||
                 (state_n == S_LO)  || (state_n == S_CHK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      addr_q   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      hi_q     <= hi_n;
      csum_q   <= csum_n;
      addr_q   <= addr_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      wr_en    <= wr_en_n;
      in_ready <= in_ready_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
    end
  end

endmodule
